// File: rtl/bneck_stream_scheduler.sv
// Streams a C*H*W feature map from a 1-cycle buffer into a bottleneck block (read strobe to sample: 1 cycle),
// then counts block outputs to signal done or a drain timeout. blk_ready low pauses issue; an in-flight sample is still presented.
module bneck_stream_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int CHANNELS     = 16,
  parameter int HEIGHT       = 112,
  parameter int WIDTH        = 112,
  parameter int EXPECTED_OUT = 200704,
  parameter int TIMEOUT      = 4096,
  parameter int ADDR_W       = $clog2(CHANNELS*HEIGHT*WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  blk_ready,
  output logic                  blk_valid,
  output logic [DATA_WIDTH-1:0] blk_data,
  output logic [7:0]            blk_channel,
  output logic [7:0]            blk_row,
  output logic [7:0]            blk_col,
  input  logic                  blk_valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int OCW = $clog2(EXPECTED_OUT + 1);
  localparam int ICW = $clog2(TIMEOUT + 1);

  localparam logic [7:0]     CH_LAST    = 8'(CHANNELS - 1);
  localparam logic [7:0]     COL_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0]     ROW_LAST   = 8'(HEIGHT - 1);
  localparam logic [OCW-1:0] OUT_TARGET = OCW'(EXPECTED_OUT);
  localparam logic [ICW-1:0] IDLE_LIMIT = ICW'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        ch_q, ch_d;
  logic [7:0]        col_q, col_d;
  logic [7:0]        row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OCW-1:0]    out_cnt_q, out_cnt_d;
  logic [ICW-1:0]    idle_cnt_q, idle_cnt_d;
  logic              error_q, error_d;
  logic              blk_valid_q, blk_valid_d;
  logic [7:0]        blk_channel_q, blk_channel_d;
  logic [7:0]        blk_row_q, blk_row_d;
  logic [7:0]        blk_col_q, blk_col_d;

  logic issue_en;
  logic last_issue;
  logic count_out;
  logic out_full;

  always_comb begin
    issue_en   = (state_q == S_ISSUE) && blk_ready;
    last_issue = issue_en && (ch_q == CH_LAST) && (col_q == COL_LAST) && (row_q == ROW_LAST);
    count_out  = blk_valid_out && ((state_q == S_ISSUE) || (state_q == S_DRAIN));

    out_cnt_d = out_cnt_q;
    if (count_out && (out_cnt_q != OUT_TARGET)) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
    out_full = (out_cnt_d == OUT_TARGET);

    idle_cnt_d = idle_cnt_q;
    if (blk_valid_out) begin
      idle_cnt_d = '0;
    end else if (state_q == S_DRAIN) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    // Channel is the fastest-moving index, then column, then row.
    ch_d   = ch_q;
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (issue_en) begin
      addr_d = addr_q + 1'b1;
      if (ch_q == CH_LAST) begin
        ch_d = '0;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end

    blk_valid_d   = issue_en;
    blk_channel_d = issue_en ? ch_q  : blk_channel_q;
    blk_row_d     = issue_en ? row_q : blk_row_q;
    blk_col_d     = issue_en ? col_q : blk_col_q;

    state_d = state_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_ISSUE;
          error_d    = 1'b0;
          ch_d       = '0;
          col_d      = '0;
          row_d      = '0;
          addr_d     = '0;
          out_cnt_d  = '0;
          idle_cnt_d = '0;
        end
      end
      S_ISSUE: begin
        if (last_issue) begin
          state_d = out_full ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_full) begin
          state_d = S_DONE;
        end else if (idle_cnt_d == IDLE_LIMIT) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      out_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      error_q       <= 1'b0;
      blk_valid_q   <= 1'b0;
      blk_channel_q <= '0;
      blk_row_q     <= '0;
      blk_col_q     <= '0;
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      col_q         <= col_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      out_cnt_q     <= out_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      error_q       <= error_d;
      blk_valid_q   <= blk_valid_d;
      blk_channel_q <= blk_channel_d;
      blk_row_q     <= blk_row_d;
      blk_col_q     <= blk_col_d;
    end
  end

  // Data is masked so the sample bus reads zero whenever no sample is presented.
  assign rd_en       = issue_en;
  assign rd_addr     = addr_q;
  assign blk_valid   = blk_valid_q;
  assign blk_data    = blk_valid_q ? rd_data : '0;
  assign blk_channel = blk_channel_q;
  assign blk_row     = blk_row_q;
  assign blk_col     = blk_col_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign error       = error_q;

endmodule
